// File: rtl/exec_unit_param_if.sv
`default_nettype none
// =====================================================================
// Module   : exec_unit_param_if
// Purpose  : command/result handshake bundle for the execute stage.
// Revision : 1.0
// =====================================================================
interface exec_unit_param_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_shop;
    logic [3:0]       in_aluop;
    logic             in_s;
    logic             in_mul;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_f;
    logic             out_wr;
    logic             out_und;
    logic [3:0]       out_nzcv;

    modport master (
        output in_valid, in_a, in_b, in_shamt, in_shop, in_aluop, in_s, in_mul, out_ready,
        input  in_ready, out_valid, out_f, out_wr, out_und, out_nzcv
    );

    modport slave (
        input  in_valid, in_a, in_b, in_shamt, in_shop, in_aluop, in_s, in_mul, out_ready,
        output in_ready, out_valid, out_f, out_wr, out_und, out_nzcv
    );
endinterface
`default_nettype wire

// File: rtl/exec_unit_param.sv
`default_nettype none
// =====================================================================
// Module   : exec_unit_param
// Purpose  : multi-cycle barrel-shift + ALU execute stage owning NZCV;
//            iterative multiplier built only when EXEC_MUL_EN is defined.
// Revision : 1.0
// =====================================================================
module exec_unit_param #(
    parameter int WIDTH = 32,
    parameter int SHW   = 8
) (
    input wire               clk,
    input wire               rst,
    exec_unit_param_if.slave bus
);
    localparam int c_lw = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
`ifdef EXEC_MUL_EN
        S_MUL  = 3'd4,
`endif
        S_DONE = 3'd3
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [2:0]       shop_q, shop_d;
    logic [3:0]       aluop_q, aluop_d, nzcv_q, nzcv_d;
    logic             s_q, s_d, mul_q, mul_d, wr_q, wr_d, und_q, und_d;
`ifdef EXEC_MUL_EN
    logic [c_lw-1:0]  cnt_q, cnt_d;
`endif

    logic                    cin;
    logic [WIDTH:0]          lsl_x, lsr_x;
    logic signed [WIDTH:0]   asr_x;
    logic [WIDTH-1:0]        ror_res, sh_res;
    logic                    sh_c;

    assign cin     = nzcv_q[1];
    // Carry falls out of the extra bit of each widened shift, covering amt>=WIDTH too.
    assign lsl_x   = {1'b0, b_q} << shamt_q;
    assign lsr_x   = {b_q, 1'b0} >> shamt_q;
    assign asr_x   = $signed({b_q, 1'b0}) >>> shamt_q;
    assign ror_res = WIDTH'({b_q, b_q} >> shamt_q[c_lw-1:0]);

    always_comb begin
        sh_res = b_q;
        sh_c   = cin;
        if (shop_q == 3'b100) begin
            sh_res = {cin, b_q[WIDTH-1:1]};
            sh_c   = b_q[0];
        end else if (shamt_q != '0) begin
            case (shop_q)
                3'b001:  {sh_res, sh_c} = lsr_x;
                3'b010:  {sh_res, sh_c} = asr_x;
                3'b011: begin
                    sh_res = ror_res;
                    sh_c   = ror_res[WIDTH-1];
                end
                default: {sh_c, sh_res} = lsl_x;
            endcase
        end
    end

    logic [WIDTH-1:0] alu_x, alu_y, logic_f, alu_f;
    logic             alu_ci, alu_arith, alu_c, alu_v;
    logic [WIDTH:0]   alu_sum;

    always_comb begin
        alu_x     = a_q;
        alu_y     = sh_res;
        alu_ci    = 1'b0;
        alu_arith = 1'b1;
        logic_f   = '0;
        case (aluop_q)
            4'h2, 4'hA: begin alu_y = ~sh_res; alu_ci = 1'b1; end
            4'h3: begin alu_x = sh_res; alu_y = ~a_q; alu_ci = 1'b1; end
            4'h5: alu_ci = cin;
            4'h6: begin alu_y = ~sh_res; alu_ci = cin; end
            4'h7: begin alu_x = sh_res; alu_y = ~a_q; alu_ci = cin; end
            4'h0, 4'h8: begin alu_arith = 1'b0; logic_f = a_q & sh_res; end
            4'h1, 4'h9: begin alu_arith = 1'b0; logic_f = a_q ^ sh_res; end
            4'hC: begin alu_arith = 1'b0; logic_f = a_q | sh_res; end
            4'hD: begin alu_arith = 1'b0; logic_f = sh_res; end
            4'hE: begin alu_arith = 1'b0; logic_f = a_q & ~sh_res; end
            4'hF: begin alu_arith = 1'b0; logic_f = ~sh_res; end
            default: ;
        endcase
    end

    assign alu_sum = {1'b0, alu_x} + {1'b0, alu_y} + (WIDTH+1)'(alu_ci);
    assign alu_f   = alu_arith ? alu_sum[WIDTH-1:0] : logic_f;
    assign alu_c   = alu_arith ? alu_sum[WIDTH] : sh_c;
    assign alu_v   = alu_arith ? ((alu_x[WIDTH-1] == alu_y[WIDTH-1]) &&
                                  (alu_sum[WIDTH-1] != alu_x[WIDTH-1])) : nzcv_q[0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        shamt_d = shamt_q;
        shop_d  = shop_q;
        aluop_d = aluop_q;
        s_d     = s_q;
        mul_d   = mul_q;
        f_d     = f_q;
        wr_d    = wr_q;
        und_d   = und_q;
        nzcv_d  = nzcv_q;
`ifdef EXEC_MUL_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    shamt_d = bus.in_shamt;
                    shop_d  = bus.in_shop;
                    aluop_d = bus.in_aluop;
                    s_d     = bus.in_s;
                    mul_d   = bus.in_mul;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_EXEC;
`ifdef EXEC_MUL_EN
                if (mul_q) begin
                    state_d = S_MUL;
                    f_d     = '0;
                    cnt_d   = '0;
                end
`endif
            end
            S_EXEC: begin
                state_d = S_DONE;
                if (mul_q) begin
                    f_d   = '0;
                    wr_d  = 1'b0;
                    und_d = 1'b1;
                end else begin
                    f_d   = alu_f;
                    wr_d  = (aluop_q[3:2] != 2'b10);
                    und_d = 1'b0;
                    if (s_q) nzcv_d = {alu_f[WIDTH-1], (alu_f == '0), alu_c, alu_v};
                end
            end
`ifdef EXEC_MUL_EN
            S_MUL: begin
                // Shift-add: multiplicand walks left, multiplier walks right.
                f_d   = f_q + (b_q[0] ? a_q : '0);
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + c_lw'(1);
                if (cnt_q == c_lw'(WIDTH-1)) begin
                    state_d = S_DONE;
                    wr_d    = 1'b1;
                    und_d   = 1'b0;
                    if (s_q) nzcv_d[3:2] = {f_d[WIDTH-1], (f_d == '0)};
                end
            end
`endif
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            shamt_q     <= '0;
            shop_q      <= '0;
            aluop_q     <= '0;
            s_q         <= 1'b0;
            mul_q       <= 1'b0;
            f_q         <= '0;
            wr_q        <= 1'b0;
            und_q       <= 1'b0;
            nzcv_q      <= '0;
`ifdef EXEC_MUL_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            shamt_q     <= shamt_d;
            shop_q      <= shop_d;
            aluop_q     <= aluop_d;
            s_q         <= s_d;
            mul_q       <= mul_d;
            f_q         <= f_d;
            wr_q        <= wr_d;
            und_q       <= und_d;
            nzcv_q      <= nzcv_d;
`ifdef EXEC_MUL_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_f     = f_q;
    assign bus.out_wr    = wr_q;
    assign bus.out_und   = und_q;
    assign bus.out_nzcv  = nzcv_q;
endmodule
`default_nettype wire

// File: tb/tb_exec_unit_param.sv
`default_nettype none
// =====================================================================
// Module   : tb_exec_unit_param
// Purpose  : directed vectors for exec_unit_param, queue scoreboard
//            popped by an output monitor.
// Revision : 1.0
// =====================================================================
module tb_exec_unit_param;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exec_unit_param_if #(.WIDTH(W), .SHW(8)) bus ();
    exec_unit_param #(.WIDTH(W), .SHW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [W-1:0] f;
        logic         wr;
        logic         und;
        logic [3:0]   nzcv;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("out_f",    64'(bus.out_f),    64'(e.f));
                    chk("out_wr",   64'(bus.out_wr),   64'(e.wr));
                    chk("out_und",  64'(bus.out_und),  64'(e.und));
                    chk("out_nzcv", 64'(bus.out_nzcv), 64'(e.nzcv));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic drive(input logic [3:0] op, input logic [2:0] shop, input logic [7:0] amt,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic mul);
        bus.in_aluop = op;
        bus.in_shop  = shop;
        bus.in_shamt = amt;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_s     = s;
        bus.in_mul   = mul;
    endtask

    task automatic push(input logic [W-1:0] f, input logic wr, input logic und, input logic [3:0] nzcv);
        exp_t e;
        e.f = f; e.wr = wr; e.und = und; e.nzcv = nzcv;
        sb.push_back(e);
    endtask

    task automatic idle_wait();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("return_idle", 64'(bus.in_ready), 64'd1);
    endtask

    // Issue one command, measure edges from the accept edge to out_valid.
    task automatic issue_and_wait(output int lat);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [2:0] shop, input logic [7:0] amt,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic mul,
                       input logic [W-1:0] ef, input logic ewr, input logic eund,
                       input logic [3:0] enzcv, input int elat);
        int lat;
        push(ef, ewr, eund, enzcv);
        @(negedge clk);
        drive(op, shop, amt, a, b, s, mul);
        bus.in_valid = 1'b1;
        issue_and_wait(lat);
        chk("latency", 64'(lat), 64'(elat));
        idle_wait();
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(4'h0, 3'b000, 8'd0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_f",     64'(bus.out_f),     64'd0);
        chk("rst_out_wr",    64'(bus.out_wr),    64'd0);
        chk("rst_out_und",   64'(bus.out_und),   64'd0);
        chk("rst_out_nzcv",  64'(bus.out_nzcv),  64'd0);

        //   op    shop    amt    A             B             S     mul    F             wr    und   NZCV      lat
        run(4'h4, 3'b000, 8'd0,  32'h7FFFFFFF, 32'h1,        1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0, 4'b1001, 3); // ADD
        run(4'hA, 3'b000, 8'd0,  32'h5,        32'h5,        1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0110, 3); // CMP
        run(4'hA, 3'b000, 8'd0,  32'h5,        32'h3,        1'b0, 1'b0, 32'h2,        1'b0, 1'b0, 4'b0110, 3); // CMP no S
        run(4'hD, 3'b011, 8'd32, 32'h0,        32'h80000001, 1'b1, 1'b0, 32'h80000001, 1'b1, 1'b0, 4'b1010, 3); // ROR #32
        run(4'hD, 3'b000, 8'd33, 32'h0,        32'h80000001, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0100, 3); // LSL #33
        run(4'hD, 3'b001, 8'd1,  32'h0,        32'h3,        1'b1, 1'b0, 32'h1,        1'b1, 1'b0, 4'b0010, 3); // LSR #1
        run(4'hD, 3'b100, 8'd0,  32'h0,        32'h2,        1'b1, 1'b0, 32'h80000001, 1'b1, 1'b0, 4'b1000, 3); // RRX
        run(4'h2, 3'b000, 8'd0,  32'h0,        32'h1,        1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b1000, 3); // SUB
        run(4'hD, 3'b010, 8'd40, 32'h0,        32'h80000000, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 4'b1010, 3); // ASR #40
        run(4'h5, 3'b000, 8'd0,  32'h1,        32'h1,        1'b1, 1'b0, 32'h3,        1'b1, 1'b0, 4'b0000, 3); // ADC
        run(4'hD, 3'b000, 8'd32, 32'h0,        32'h1,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0110, 3); // LSL #32
        run(4'hD, 3'b001, 8'd32, 32'h0,        32'h80000000, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 4'b0110, 3); // LSR #32
        run(4'h3, 3'b010, 8'd1,  32'h3,        32'hA,        1'b1, 1'b0, 32'h2,        1'b1, 1'b0, 4'b0010, 3); // RSB
        run(4'hD, 3'b011, 8'd4,  32'h0,        32'hF1,       1'b1, 1'b0, 32'h1000000F, 1'b1, 1'b0, 4'b0000, 3); // ROR #4
        run(4'hE, 3'b000, 8'd0,  32'hFF,       32'h0F,       1'b0, 1'b0, 32'hF0,       1'b1, 1'b0, 4'b0000, 3); // BIC
        run(4'h8, 3'b000, 8'd0,  32'hF0,       32'h0F,       1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 4'b0100, 3); // TST

        // Backpressure: EOR S, A=0xFF00, B=0x1FE1 LSR #1 -> 0xF0F0, shifter carry 1.
        bus.out_ready = 1'b0;
        push(32'hF0F0, 1'b1, 1'b0, 4'b0010);
        @(negedge clk);
        drive(4'h1, 3'b001, 8'd1, 32'hFF00, 32'h1FE1, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        issue_and_wait(lat);
        chk("bp_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                drive(4'h4, 3'b000, 8'd0, 32'h1, 32'h1, 1'b1, 1'b0);
                bus.in_valid = 1'b1;
            end
            if (i == 3) bus.in_valid = 1'b0;
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_f",     64'(bus.out_f),     64'hF0F0);
            chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        idle_wait();
        repeat (6) @(posedge clk);

`ifdef EXEC_MUL_EN
        run(4'h0, 3'b000, 8'd0, 32'h6, 32'h7, 1'b1, 1'b1, 32'd42, 1'b1, 1'b0, 4'b0010, 34);
`else
        run(4'h0, 3'b000, 8'd0, 32'h6, 32'h7, 1'b1, 1'b1, 32'd0,  1'b0, 1'b1, 4'b0010, 3);
`endif

        // Reset while in EXEC discards the pending ADD and clears flags.
        @(negedge clk);
        drive(4'h4, 3'b000, 8'd0, 32'h1, 32'h1, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_nzcv",      64'(bus.out_nzcv),  64'd0);
        repeat (8) @(posedge clk);

        run(4'h4, 3'b000, 8'd0, 32'h2, 32'h3, 1'b0, 1'b0, 32'h5, 1'b1, 1'b0, 4'b0000, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
